// File: rtl/rmux_pkg.sv
// Shared types and widths for the reversible-mux scan controller and its bench.
package rmux_pkg;

    localparam int WORD_W = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/rmux_scan_ctrl_if.sv
// Upstream word handshake and downstream result handshake of the scan controller.
interface rmux_scan_ctrl_if;
    import rmux_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, err
    );

endinterface

// File: rtl/rmux_sample_slot.sv
// Slot sequencer: settle counter per select slot plus the select counter itself.
// Emits a sample strobe at the end of each slot and a last strobe on slot 3.
module rmux_sample_slot
    import rmux_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    output logic [SEL_W-1:0] sel,
    output logic             sample,
    output logic             last
);

    localparam logic [2:0] SETTLE_LIM = 3'(SETTLE_CYC);

    logic [2:0] settle_cnt;

    assign sample = run && (settle_cnt == SETTLE_LIM);
    assign last   = sample && (sel == '1);

    // Settle and select counters; sel wraps 3->0 on the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            sel        <= '0;
        end else if (start) begin
            settle_cnt <= '0;
            sel        <= '0;
        end else if (run) begin
            if (sample) begin
                settle_cnt <= '0;
                sel        <= sel + 2'd1;
            end else begin
                settle_cnt <= settle_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/rmux_scan_ctrl.sv
// Scan controller around a 4:1 reversible mux: accepts a word, steps the mux
// select through all four inputs, reassembles the sampled bits and flags any
// difference from the accepted word.
module rmux_scan_ctrl
    import rmux_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1,
    parameter bit          CHECK_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    rmux_scan_ctrl_if.slave   bus,
    output logic [WORD_W-1:0] mux_in,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_out,
    output logic              busy
);

    scan_state_t       state, state_nxt;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] assembled;
    logic              err_q;
    logic              accept;
    logic              sample;
    logic              last;

    assign accept = (state == IDLE) && bus.in_valid;

    rmux_sample_slot #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .run    (state == SCAN),
        .sel    (mux_sel),
        .sample (sample),
        .last   (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SCAN;
            SCAN:    if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Current word with the bit under the active select replaced by the mux output.
    always_comb begin
        assembled          = data_q;
        assembled[mux_sel] = mux_out;
    end

    // Word capture, deserialise and compare; err uses the bit sampled on the final edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            mux_in <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                word_q <= bus.in_data;
                mux_in <= bus.in_data;
            end
            if (sample) begin
                data_q <= assembled;
            end
            if (last) begin
                err_q <= CHECK_EN && (assembled != word_q);
            end else if ((state == DONE) && bus.out_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = data_q;
    assign bus.err       = err_q;
    assign busy          = (state != IDLE);

endmodule
